// File: rtl/dec_channel_scheduler.sv
// Round-robin scheduler that time-shares one decimation datapath among NUM_CH channels,
// keeping every DEC-th sample per channel and sequencing runtime decimation changes.
module dec_channel_scheduler #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CH      = 4,
   parameter int MAX_DEC     = 8,
   parameter int DEFAULT_DEC = 3,
   localparam int CH_W  = $clog2(NUM_CH),
   localparam int DEC_W = $clog2(MAX_DEC + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_valid,
   input  logic [DEC_W-1:0]             cfg_dec,
   output logic                         cfg_ready,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic                         busy
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_APPLY} state_t;

   state_t           state, state_nxt;
   logic [DEC_W-1:0] dec_factor;
   logic [DEC_W-1:0] cfg_pend;
   logic [DEC_W-1:0] phase [NUM_CH];
   logic [CH_W-1:0]  rr_ptr;

   logic             grant_en;
   logic             grant_any;
   logic [CH_W-1:0]  grant_ch;
   logic [CH_W-1:0]  scan_ch;
   int unsigned      scan_idx;
   logic             xfer;
   logic             keep;

   function automatic logic [DEC_W-1:0] clamp_dec(input logic [DEC_W-1:0] d);
      if (d == '0)
         return DEC_W'(1);
      else if (d > DEC_W'(MAX_DEC))
         return DEC_W'(MAX_DEC);
      else
         return d;
   endfunction

   // Rotating priority scan starting at rr_ptr; grant is masked while rst is held.
   always_comb begin
      grant_en  = !rst && (state == S_RUN) && (!out_valid || out_ready);
      grant_any = 1'b0;
      grant_ch  = '0;
      scan_idx  = 0;
      scan_ch   = '0;
      ch_ready  = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         scan_idx = 32'(rr_ptr) + k;
         if (scan_idx >= NUM_CH)
            scan_idx = scan_idx - NUM_CH;
         scan_ch = CH_W'(scan_idx);
         if (!grant_any && ch_valid[scan_ch]) begin
            grant_any = 1'b1;
            grant_ch  = scan_ch;
         end
      end
      if (grant_en && grant_any)
         ch_ready[grant_ch] = 1'b1;
   end

   assign xfer = grant_en && grant_any;
   assign keep = (phase[grant_ch] == '0);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      cfg_ready = 1'b0;
      unique case (state)
         S_RUN:   if (cfg_valid) state_nxt = S_DRAIN;
         S_DRAIN: begin
            busy = 1'b1;
            if (!out_valid || out_ready) state_nxt = S_APPLY;
         end
         S_APPLY: begin
            busy      = 1'b1;
            cfg_ready = 1'b1;
            state_nxt = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         dec_factor <= DEC_W'(DEFAULT_DEC);
         cfg_pend   <= '0;
         rr_ptr     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            phase[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_RUN && cfg_valid)
            cfg_pend <= cfg_dec;
         if (xfer) begin
            rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            phase[grant_ch] <= (phase[grant_ch] == dec_factor - DEC_W'(1)) ?
                               '0 : phase[grant_ch] + DEC_W'(1);
         end
         if (state == S_APPLY) begin
            dec_factor <= clamp_dec(cfg_pend);
            for (int unsigned i = 0; i < NUM_CH; i++)
               phase[i] <= '0;
         end
         // Reload takes precedence over accept so back-to-back samples leave no bubble.
         if (xfer && keep) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[32'(grant_ch)*DATA_WIDTH +: DATA_WIDTH];
            out_ch    <= grant_ch;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
